// File: rtl/top_level.sv
// Single-cycle 8-bit load/store core: 9-bit instruction ROM, 8 registers, Z flag, 256-byte data RAM.
// A start pulse runs the program from PC 0 until a HALT instruction retires.
module inst_rom #(
   parameter int PC_W = 10
) (
   input  logic [PC_W-1:0] addr_i,
   output logic [8:0]      data_o
);
   // Loaded hierarchically with the program image; read combinationally.
   logic [8:0] ROM_core [0:(1<<PC_W)-1];

   assign data_o = ROM_core[addr_i];
endmodule

module data_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] Core [0:DEPTH-1];

   // Write port; contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         Core[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = Core[addr_i];
endmodule

module top_level #(
   parameter int PC_W     = 10,
   parameter int DATA_W   = 8,
   parameter int DM_DEPTH = 256
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic start,
   output logic halt
);
   localparam int AW = $clog2(DM_DEPTH);
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_SHF = 3'd3,
                          OP_LDI = 3'd4, OP_LD  = 3'd5, OP_ST  = 3'd6, OP_CTL = 3'd7;
   localparam logic [8:0] HALT_WORD = 9'b111_100000;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d, pc_inc_s, pc_br_s;
   logic [DATA_W-1:0] regs_q [0:7];
   logic              z_q, z_d, halt_q, halt_d;
   logic [8:0]        rom_word_s, instr_s;
   logic [2:0]        op_s, rd_s, rs_s, wr_addr_s;
   logic [DATA_W-1:0] rd_val_s, rs_val_s, dm_rdata_s, wr_data_s;
   logic              wr_en_s, dm_we_s;

   inst_rom #(.PC_W(PC_W)) inst_module (
      .addr_i (pc_q),
      .data_o (rom_word_s)
   );

   data_ram #(.DATA_W(DATA_W), .DEPTH(DM_DEPTH)) data_module (
      .clk_i   (CLK),
      .we_i    (dm_we_s),
      .addr_i  (rs_val_s[AW-1:0]),
      .wdata_i (rd_val_s),
      .rdata_o (dm_rdata_s)
   );

   // Unprogrammed (unknown) ROM words behave as HALT.
   assign instr_s  = $isunknown(rom_word_s) ? HALT_WORD : rom_word_s;
   assign op_s     = instr_s[8:6];
   assign rd_s     = instr_s[5:3];
   assign rs_s     = instr_s[2:0];
   assign rd_val_s = regs_q[rd_s];
   assign rs_val_s = regs_q[rs_s];
   assign pc_inc_s = pc_q + PC_W'(1);
   assign pc_br_s  = pc_q + {{(PC_W-5){instr_s[4]}}, instr_s[4:0]};
   assign halt     = halt_q;

   // Next-state decode: start has priority and suppresses execution in its cycle.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      z_d       = z_q;
      halt_d    = halt_q;
      wr_en_s   = 1'b0;
      wr_addr_s = rd_s;
      wr_data_s = '0;
      dm_we_s   = 1'b0;
      if (start) begin
         pc_d    = '0;
         halt_d  = 1'b0;
         state_d = S_RUN;
      end else if (state_q == S_RUN) begin
         pc_d = pc_inc_s;
         case (op_s)
            OP_ADD: begin wr_en_s = 1'b1; wr_data_s = rd_val_s + rs_val_s; end
            OP_SUB: begin wr_en_s = 1'b1; wr_data_s = rd_val_s - rs_val_s; end
            OP_AND: begin wr_en_s = 1'b1; wr_data_s = rd_val_s & rs_val_s; end
            OP_SHF: begin
               wr_en_s   = 1'b1;
               wr_data_s = rs_s[0] ? (rd_val_s >> 1) : (rd_val_s << 1);
            end
            OP_LDI: begin
               wr_en_s   = 1'b1;
               wr_addr_s = 3'd0;
               wr_data_s = {{(DATA_W-6){1'b0}}, instr_s[5:0]};
            end
            OP_LD:  begin wr_en_s = 1'b1; wr_data_s = dm_rdata_s; end
            OP_ST:  dm_we_s = 1'b1;
            OP_CTL: begin
               if (!instr_s[5]) begin
                  if (z_q) pc_d = pc_br_s;
                  else     pc_d = pc_inc_s;
               end else if (instr_s[4:0] != 5'd0) begin
                  pc_d = pc_br_s;
               end else begin
                  pc_d    = pc_q;
                  halt_d  = 1'b1;
                  state_d = S_HALT;
               end
            end
            default: pc_d = pc_inc_s;
         endcase
         if (wr_en_s) z_d = (wr_data_s == '0);
         else         z_d = z_q;
      end else begin
         state_d = state_q;
      end
   end

   // Architectural state update.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         z_q     <= 1'b0;
         halt_q  <= 1'b0;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         z_q     <= z_d;
         halt_q  <= halt_d;
         if (wr_en_s) regs_q[wr_addr_s] <= wr_data_s;
      end
   end
endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: directed programs plus random straight-line programs,
// each checked cycle by cycle against an instruction-level model of the ISA.
module tb_top_level;
   logic CLK = 1'b0;
   logic RSTn;
   logic start;
   logic halt;

   top_level dut (.CLK(CLK), .RSTn(RSTn), .start(start), .halt(halt));

   always #5 CLK = ~CLK;

   localparam logic [8:0] HALT_W = 9'b111_100000;

   int total = 0;
   int bad   = 0;
   logic [8:0] prog [0:1023];
   int m_r [8];
   int m_mem [256];
   int m_z, m_pc, m_run, m_halt;
   int mem_valid = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] enc(input int op, input int rd, input int rs);
      return {3'(op), 3'(rd), 3'(rs)};
   endfunction

   function automatic logic [8:0] ldi(input int v);
      return {3'b100, 6'(v)};
   endfunction

   function automatic logic [8:0] ctl(input int jmp, input int off);
      return {3'b111, 1'(jmp), 5'(off)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = 0;
      m_z = 0; m_pc = 0; m_run = 0; m_halt = 0;
   endtask

   // One instruction of the ISA, computed with plain integer arithmetic.
   task automatic model_step();
      logic [8:0] w;
      int op, rd, rs, off, v, npc;
      if (m_run == 0) return;
      w   = prog[m_pc];
      op  = int'(w[8:6]);
      rd  = int'(w[5:3]);
      rs  = int'(w[2:0]);
      off = int'(w[4:0]);
      if (off >= 16) off = off - 32;
      v   = -1;
      npc = (m_pc + 1) % 1024;
      case (op)
         0: v = (m_r[rd] + m_r[rs]) % 256;
         1: v = (m_r[rd] - m_r[rs] + 256) % 256;
         2: v = m_r[rd] & m_r[rs];
         3: v = (rs % 2 == 0) ? (m_r[rd] * 2) % 256 : m_r[rd] / 2;
         4: begin rd = 0; v = int'(w[5:0]); end
         5: v = m_mem[m_r[rs]];
         6: m_mem[m_r[rs]] = m_r[rd];
         default: begin
            if (w[5] == 1'b0) begin
               if (m_z != 0) npc = (m_pc + off + 1024) % 1024;
            end else if (off != 0) begin
               npc = (m_pc + off + 1024) % 1024;
            end else begin
               npc = m_pc; m_halt = 1; m_run = 0;
            end
         end
      endcase
      if (v >= 0) begin
         m_r[rd] = v;
         m_z = (v == 0) ? 1 : 0;
      end
      m_pc = npc;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 1024; i++) prog[i] = HALT_W;
   endtask

   task automatic load_prog();
      for (int i = 0; i < 1024; i++) dut.inst_module.ROM_core[i] = prog[i];
   endtask

   task automatic compare_state(input string tag);
      for (int i = 0; i < 8; i++)
         check_eq($sformatf("%s_r%0d", tag, i), int'(dut.regs_q[i]), m_r[i]);
      check_eq({tag, "_z"}, int'(dut.z_q), m_z);
      check_eq({tag, "_pc"}, int'(dut.pc_q), m_pc);
      if (mem_valid != 0)
         for (int a = 0; a < 256; a++)
            check_eq($sformatf("%s_mem%0d", tag, a), int'(dut.data_module.Core[a]), m_mem[a]);
   endtask

   // Reset is applied between clock edges to show it acts without one.
   task automatic do_reset(input string tag);
      #2;
      RSTn = 1'b0;
      model_reset();
      #1;
      check_eq({tag, "_rst_halt"}, int'(halt), 0);
      check_eq({tag, "_rst_pc"}, int'(dut.pc_q), 0);
      compare_state({tag, "_rst"});
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      m_pc = 0; m_halt = 0; m_run = 1;
      check_eq("start_halt_clr", int'(halt), 0);
      check_eq("start_pc", int'(dut.pc_q), 0);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         model_step();
         #1;
         check_eq("run_halt", int'(halt), m_halt);
      end
   endtask

   task automatic run_to_halt(input string tag, output int dut_cyc);
      int cyc;
      cyc = 0;
      dut_cyc = -1;
      while (m_halt == 0 && cyc < 3000) begin
         @(posedge CLK);
         model_step();
         #1;
         cyc++;
         if (halt === 1'b1 && dut_cyc < 0) dut_cyc = cyc;
         check_eq({tag, "_halt"}, int'(halt), m_halt);
      end
      check_eq({tag, "_done"}, int'(halt), 1);
      compare_state(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc, len, k, lim;
      RSTn  = 1'b0;
      start = 1'b0;
      model_reset();
      for (int a = 0; a < 256; a++) m_mem[a] = 0;
      clear_prog();
      load_prog();
      repeat (2) @(negedge CLK);
      #1;
      check_eq("reset_halt", int'(halt), 0);
      compare_state("reset");
      @(negedge CLK);
      RSTn = 1'b1;

      // LDI 5; ADD r1,r0; HALT
      clear_prog();
      prog[0] = 9'b100_000101; prog[1] = 9'b000_001_000; prog[2] = HALT_W;
      load_prog();
      pulse_start();
      run_to_halt("t1", dc);
      check_eq("t1_r1", int'(dut.regs_q[1]), 5);
      check_eq("t1_cycles", dc, 3);
      do_reset("t1");

      // Taken BZ skips LDI 9
      clear_prog();
      prog[0] = ldi(3); prog[1] = enc(1, 0, 0); prog[2] = ctl(0, 2); prog[3] = ldi(9); prog[4] = HALT_W;
      load_prog();
      pulse_start();
      run_to_halt("t2", dc);
      check_eq("t2_r0", int'(dut.regs_q[0]), 0);
      check_eq("t2_z", int'(dut.z_q), 1);
      check_eq("t2_cycles", dc, 4);
      do_reset("t2");

      // Store then load through r1 = 0
      clear_prog();
      prog[0] = ldi(42); prog[1] = enc(6, 0, 1); prog[2] = enc(5, 2, 1); prog[3] = HALT_W;
      load_prog();
      pulse_start();
      run_to_halt("t3", dc);
      check_eq("t3_mem0", int'(dut.data_module.Core[0]), 42);
      check_eq("t3_r2", int'(dut.regs_q[2]), 42);
      do_reset("t3");

      // Backward branch from PC 1 wraps to 1009 (HALT filler there)
      clear_prog();
      prog[0] = ldi(0); prog[1] = ctl(0, -16);
      load_prog();
      pulse_start();
      run_to_halt("wrap", dc);
      check_eq("wrap_pc", int'(dut.pc_q), 1009);
      check_eq("wrap_cycles", dc, 3);
      do_reset("wrap");

      // Fill every data address with its own index
      clear_prog();
      prog[0] = ldi(1); prog[1] = enc(0, 3, 0); prog[2] = enc(6, 1, 1); prog[3] = enc(0, 1, 3);
      prog[4] = ctl(0, 2); prog[5] = ctl(1, -3);
      load_prog();
      mem_valid = 1;
      pulse_start();
      run_to_halt("fill", dc);
      check_eq("fill_cycles", dc, 1026);
      check_eq("fill_mem128", int'(dut.data_module.Core[128]), 128);
      do_reset("fill");

      // Shifts: 0x81 << 1 = 0x02, then >> 1 twice = 0
      clear_prog();
      prog[0] = ldi(32); prog[1] = enc(0, 1, 0); prog[2] = enc(0, 1, 1); prog[3] = enc(0, 1, 1);
      prog[4] = ldi(1); prog[5] = enc(0, 1, 0); prog[6] = enc(3, 1, 0);
      load_prog();
      pulse_start();
      run_to_halt("t4a", dc);
      check_eq("t4a_r1", int'(dut.regs_q[1]), 2);
      check_eq("t4a_z", int'(dut.z_q), 0);
      clear_prog();
      prog[0] = enc(3, 1, 1); prog[1] = enc(3, 1, 1);
      load_prog();
      pulse_start();
      run_to_halt("t4b", dc);
      check_eq("t4b_r1", int'(dut.regs_q[1]), 0);
      check_eq("t4b_z", int'(dut.z_q), 1);

      // Random straight-line programs with forward-only branches
      for (int p = 0; p < 25; p++) begin
         clear_prog();
         len = int'($urandom_range(10, 40));
         for (int i = 0; i < len; i++) begin
            k   = int'($urandom_range(0, 8));
            lim = (len - i < 15) ? len - i : 15;
            case (k)
               0, 1, 2, 3: prog[i] = enc(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
               4: prog[i] = ldi(int'($urandom_range(0, 63)));
               5: prog[i] = enc(5, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
               6: prog[i] = enc(6, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
               7: prog[i] = ctl(0, int'($urandom_range(1, lim)));
               default: prog[i] = ctl(1, int'($urandom_range(1, lim)));
            endcase
         end
         load_prog();
         pulse_start();
         run_to_halt($sformatf("rnd%0d", p), dc);
      end

      // Countdown loop from 10; restarted mid-run, then rerun after halt
      clear_prog();
      prog[0] = ldi(0); prog[1] = enc(2, 1, 0); prog[2] = ldi(1); prog[3] = enc(0, 1, 0);
      prog[4] = ldi(10); prog[5] = enc(1, 0, 1); prog[6] = ctl(0, 2); prog[7] = ctl(1, -2);
      load_prog();
      pulse_start();
      run_cycles(9);
      pulse_start();
      run_to_halt("t5", dc);
      check_eq("t5_cycles", dc, 35);
      check_eq("t5_r0", int'(dut.regs_q[0]), 0);
      check_eq("t5_z", int'(dut.z_q), 1);
      pulse_start();
      run_to_halt("t6", dc);
      check_eq("t6_cycles", dc, 35);
      do_reset("t6");
      pulse_start();
      run_cycles(12);
      do_reset("t5mid");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
